// File: rtl/jtag_tap.sv
// TAP controller: oversamples TCK/TMS/TDI in clk, runs the 1149.1 state machine,
// and multiplexes IDCODE, BYPASS or a board data register onto TDO.
module jtag_tap #(
    parameter int          N_DR     = 64,
    parameter int          TAP_BASE = 1,
    parameter logic [31:0] IDCODE   = 32'h0000_0C53
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tck,
    input  logic            tms,
    input  logic            tdi,
    output logic            tdo,
    output logic            tdo_en,
    output logic            tap_tdi,
    input  logic [N_DR-1:0] tap_tdo_in,
    output logic            tap_capture,
    output logic            tap_shift,
    output logic            tap_update,
    output logic [9:0]      tap_insn
);

    // state    | meaning
    // TLR      | test-logic-reset, instruction forced to IDCODE
    // RTI      | run-test/idle
    // *_DR     | data register scan path
    // *_IR     | instruction register scan path
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } state_t;

    state_t      state_q, state_d, state_nxt;
    logic        tck_s1_q, tck_s1_d, tck_s2_q, tck_s2_d, tck_s3_q, tck_s3_d;
    logic        tms_s1_q, tms_s1_d, tms_s2_q, tms_s2_d;
    logic        tdi_s1_q, tdi_s1_d, tdi_s2_q, tdi_s2_d;
    logic [9:0]  ir_sr_q, ir_sr_d, insn_q, insn_d;
    logic [31:0] id_sr_q, id_sr_d;
    logic        bypass_q, bypass_d;
    logic        tdo_q, tdo_d, tdo_en_q, tdo_en_d, tap_tdi_q, tap_tdi_d;
    logic        capture_q, capture_d, shift_q, shift_d, update_q, update_d;

    logic        rise, fall;
    logic        sel_id, sel_board, sel_bypass;
    logic [9:0]  dr_idx;
    logic        board_bit, dr_src;

    assign rise = tck_s2_q & ~tck_s3_q;
    assign fall = ~tck_s2_q & tck_s3_q;

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            TLR:      state_nxt = tms_s2_q ? TLR    : RTI;
            RTI:      state_nxt = tms_s2_q ? SEL_DR : RTI;
            SEL_DR:   state_nxt = tms_s2_q ? SEL_IR : CAP_DR;
            CAP_DR:   state_nxt = tms_s2_q ? EX1_DR : SH_DR;
            SH_DR:    state_nxt = tms_s2_q ? EX1_DR : SH_DR;
            EX1_DR:   state_nxt = tms_s2_q ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_nxt = tms_s2_q ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_nxt = tms_s2_q ? UPD_DR : SH_DR;
            UPD_DR:   state_nxt = tms_s2_q ? SEL_DR : RTI;
            SEL_IR:   state_nxt = tms_s2_q ? TLR    : CAP_IR;
            CAP_IR:   state_nxt = tms_s2_q ? EX1_IR : SH_IR;
            SH_IR:    state_nxt = tms_s2_q ? EX1_IR : SH_IR;
            EX1_IR:   state_nxt = tms_s2_q ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_nxt = tms_s2_q ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_nxt = tms_s2_q ? UPD_IR : SH_IR;
            UPD_IR:   state_nxt = tms_s2_q ? SEL_DR : RTI;
            default:  state_nxt = TLR;
        endcase
    end

    // IDCODE wins if TAP_BASE were ever 0; anything unclaimed falls to BYPASS.
    always_comb begin
        sel_id     = (insn_q == 10'd0);
        sel_board  = !sel_id && ({1'b0, insn_q} >= 11'(TAP_BASE))
                             && ({1'b0, insn_q} <  11'(TAP_BASE + N_DR));
        sel_bypass = !sel_id && !sel_board;
        dr_idx     = insn_q - 10'(TAP_BASE);
        board_bit  = 1'b0;
        for (int k = 0; k < N_DR; k++) begin
            if (dr_idx == 10'(k)) board_bit = tap_tdo_in[k];
        end
        dr_src = sel_id ? id_sr_q[0] : (sel_board ? board_bit : bypass_q);
    end

    always_comb begin
        tck_s1_d  = tck;      tck_s2_d = tck_s1_q; tck_s3_d = tck_s2_q;
        tms_s1_d  = tms;      tms_s2_d = tms_s1_q;
        tdi_s1_d  = tdi;      tdi_s2_d = tdi_s1_q;
        state_d   = state_q;
        ir_sr_d   = ir_sr_q;
        insn_d    = insn_q;
        id_sr_d   = id_sr_q;
        bypass_d  = bypass_q;
        tdo_d     = tdo_q;
        tdo_en_d  = tdo_en_q;
        tap_tdi_d = tap_tdi_q;
        capture_d = 1'b0;
        shift_d   = 1'b0;
        update_d  = 1'b0;

        if (rise) begin
            state_d   = state_nxt;
            tap_tdi_d = tdi_s2_q;
            case (state_q)
                CAP_DR: begin
                    capture_d = 1'b1;
                    if (sel_id)     id_sr_d  = IDCODE;
                    if (sel_bypass) bypass_d = 1'b0;
                end
                SH_DR: begin
                    shift_d = 1'b1;
                    if (sel_id)     id_sr_d  = {tdi_s2_q, id_sr_q[31:1]};
                    if (sel_bypass) bypass_d = tdi_s2_q;
                end
                UPD_DR: update_d = 1'b1;
                CAP_IR: ir_sr_d  = 10'b00_0000_0001;
                SH_IR:  ir_sr_d  = {tdi_s2_q, ir_sr_q[9:1]};
                UPD_IR: insn_d   = ir_sr_q;
                default: ;
            endcase
        end

        if (fall) begin
            tdo_en_d = (state_q == SH_DR) || (state_q == SH_IR);
            if (state_q == SH_IR)      tdo_d = ir_sr_q[0];
            else if (state_q == SH_DR) tdo_d = dr_src;
            else                       tdo_d = 1'b0;
        end

        if (state_d == TLR) insn_d = 10'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_s1_q  <= 1'b0; tck_s2_q <= 1'b0; tck_s3_q <= 1'b0;
            tms_s1_q  <= 1'b0; tms_s2_q <= 1'b0;
            tdi_s1_q  <= 1'b0; tdi_s2_q <= 1'b0;
            state_q   <= TLR;
            ir_sr_q   <= 10'b00_0000_0001;
            insn_q    <= 10'd0;
            id_sr_q   <= IDCODE;
            bypass_q  <= 1'b0;
            tdo_q     <= 1'b0;
            tdo_en_q  <= 1'b0;
            tap_tdi_q <= 1'b0;
            capture_q <= 1'b0;
            shift_q   <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            tck_s1_q  <= tck_s1_d; tck_s2_q <= tck_s2_d; tck_s3_q <= tck_s3_d;
            tms_s1_q  <= tms_s1_d; tms_s2_q <= tms_s2_d;
            tdi_s1_q  <= tdi_s1_d; tdi_s2_q <= tdi_s2_d;
            state_q   <= state_d;
            ir_sr_q   <= ir_sr_d;
            insn_q    <= insn_d;
            id_sr_q   <= id_sr_d;
            bypass_q  <= bypass_d;
            tdo_q     <= tdo_d;
            tdo_en_q  <= tdo_en_d;
            tap_tdi_q <= tap_tdi_d;
            capture_q <= capture_d;
            shift_q   <= shift_d;
            update_q  <= update_d;
        end
    end

    assign tdo         = tdo_q;
    assign tdo_en      = tdo_en_q;
    assign tap_tdi     = tap_tdi_q;
    assign tap_capture = capture_q;
    assign tap_shift   = shift_q;
    assign tap_update  = update_q;
    assign tap_insn    = insn_q;

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap: reset, IDCODE scan, IR scan, board DR, BYPASS, mid-scan reset.
module tb_jtag_tap;

    localparam int          N_DR   = 64;
    localparam logic [31:0] ID_VAL = 32'h0000_0C53;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tck = 1'b0, tms = 1'b1, tdi = 1'b0;
    logic            tdo, tdo_en, tap_tdi;
    logic [N_DR-1:0] tap_tdo_in = '0;
    logic            tap_capture, tap_shift, tap_update;
    logic [9:0]      tap_insn;

    int   chk_cnt = 0, pass_cnt = 0;
    int   cap_cnt = 0, shf_cnt = 0, upd_cnt = 0, multi_cnt = 0;
    logic shift_log[$];
    logic last_tdo_en;
    logic exit_tdo;

    jtag_tap #(.N_DR(N_DR), .TAP_BASE(1), .IDCODE(ID_VAL)) dut (
        .clk(clk), .rst_n(rst_n), .tck(tck), .tms(tms), .tdi(tdi),
        .tdo(tdo), .tdo_en(tdo_en), .tap_tdi(tap_tdi), .tap_tdo_in(tap_tdo_in),
        .tap_capture(tap_capture), .tap_shift(tap_shift), .tap_update(tap_update),
        .tap_insn(tap_insn)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tap_capture) cap_cnt++;
        if (tap_shift) begin
            shf_cnt++;
            shift_log.push_back(tap_tdi);
        end
        if (tap_update) upd_cnt++;
        if (int'(tap_capture) + int'(tap_shift) + int'(tap_update) > 1) multi_cnt++;
    end

    // One full TCK period; tdo/tdo_en are sampled at the end of the low phase.
    task automatic tck_pulse(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms = tms_v;
        tdi = tdi_v;
        repeat (2) @(negedge clk);
        tck = 1'b1;
        repeat (6) @(negedge clk);
        tck = 1'b0;
        repeat (6) @(negedge clk);
        tdo_v = tdo;
        last_tdo_en = tdo_en;
    endtask

    // From RTI: scan n bits through the DR path, back to RTI.
    task automatic dr_scan(input int n, input logic [63:0] tdi_bits,
                           input logic [63:0] src_bits, output logic [63:0] tdo_bits);
        logic t, d;
        tdo_bits = '0;
        shift_log.delete();
        tck_pulse(1'b1, 1'b0, t);
        tck_pulse(1'b0, 1'b0, t);
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                tap_tdo_in    = {N_DR{~src_bits[i]}};
                tap_tdo_in[4] = src_bits[i];
            end
            d = 1'b0;
            if (i > 0) d = tdi_bits[i-1];
            tck_pulse(i == n, d, t);
            if (i < n) tdo_bits[i] = t;
            else       exit_tdo = t;
        end
        tck_pulse(1'b1, 1'b0, t);
        tck_pulse(1'b0, 1'b0, t);
    endtask

    task automatic ir_scan(input logic [9:0] code, output logic [9:0] tdo_bits);
        logic t, d;
        tdo_bits = '0;
        tck_pulse(1'b1, 1'b0, t);
        tck_pulse(1'b1, 1'b0, t);
        tck_pulse(1'b0, 1'b0, t);
        for (int i = 0; i <= 10; i++) begin
            d = 1'b0;
            if (i > 0) d = code[i-1];
            tck_pulse(i == 10, d, t);
            if (i < 10) tdo_bits[i] = t;
        end
        tck_pulse(1'b1, 1'b0, t);
        tck_pulse(1'b0, 1'b0, t);
    endtask

    task automatic test_reset();
        logic t;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({tdo, tdo_en, tap_tdi, tap_capture, tap_shift, tap_update} !== 6'b0)
            $display("FAIL reset_outputs: got %b required 000000",
                     {tdo, tdo_en, tap_tdi, tap_capture, tap_shift, tap_update});
        else pass_cnt++;
        chk_cnt++;
        if (tap_insn !== 10'd0) $display("FAIL reset_insn: got %h required 000", tap_insn);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) tck_pulse(1'b1, 1'b0, t);
        chk_cnt++;
        if (tap_insn !== 10'd0) $display("FAIL tlr_insn: got %h required 000", tap_insn);
        else pass_cnt++;
        chk_cnt++;
        if (tdo_en !== 1'b0) $display("FAIL tlr_tdo_en: got %b required 0", tdo_en);
        else pass_cnt++;
        chk_cnt++;
        if (cap_cnt + shf_cnt + upd_cnt != 0)
            $display("FAIL tlr_strobes: got %0d required 0", cap_cnt + shf_cnt + upd_cnt);
        else pass_cnt++;
    endtask

    task automatic test_idcode();
        logic t;
        logic [63:0] out;
        int c0, s0;
        tck_pulse(1'b0, 1'b0, t);
        c0 = cap_cnt; s0 = shf_cnt;
        dr_scan(32, 64'd0, 64'd0, out);
        chk_cnt++;
        if (out[31:0] !== ID_VAL) $display("FAIL idcode_tdo: got %h required %h", out[31:0], ID_VAL);
        else pass_cnt++;
        chk_cnt++;
        if (cap_cnt - c0 != 1) $display("FAIL idcode_capture: got %0d required 1", cap_cnt - c0);
        else pass_cnt++;
        chk_cnt++;
        if (shf_cnt - s0 != 32) $display("FAIL idcode_shift: got %0d required 32", shf_cnt - s0);
        else pass_cnt++;
        chk_cnt++;
        if (exit_tdo !== 1'b0 || last_tdo_en !== 1'b0)
            $display("FAIL idcode_exit: got tdo=%b tdo_en=%b required 0 0", exit_tdo, last_tdo_en);
        else pass_cnt++;
    endtask

    task automatic test_ir_scan();
        logic [9:0] out;
        int u0;
        u0 = upd_cnt;
        ir_scan(10'd5, out);
        chk_cnt++;
        if (out[1:0] !== 2'b01) $display("FAIL ir_first_bits: got %b required 01", out[1:0]);
        else pass_cnt++;
        chk_cnt++;
        if (tap_insn !== 10'd5) $display("FAIL ir_insn: got %0d required 5", tap_insn);
        else pass_cnt++;
        chk_cnt++;
        if (upd_cnt != u0) $display("FAIL ir_no_update: got %0d required 0", upd_cnt - u0);
        else pass_cnt++;
    endtask

    task automatic test_board_dr();
        logic [63:0] out;
        logic [7:0]  src_v, tdi_v, log_v;
        int          nlog;
        src_v = 8'b1010_1010;
        tdi_v = 8'hC5;
        dr_scan(8, {56'd0, tdi_v}, {56'd0, src_v}, out);
        chk_cnt++;
        if (out[7:0] !== src_v) $display("FAIL board_tdo: got %b required %b", out[7:0], src_v);
        else pass_cnt++;
        log_v = '0;
        nlog = shift_log.size();
        for (int i = 0; i < nlog && i < 8; i++) log_v[i] = shift_log[i];
        chk_cnt++;
        if (nlog != 8 || log_v !== tdi_v)
            $display("FAIL board_tap_tdi: got %b (%0d shifts) required %b (8 shifts)", log_v, nlog, tdi_v);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        logic [9:0]  ir_out;
        logic [63:0] out;
        int u0;
        ir_scan(10'h3FF, ir_out);
        chk_cnt++;
        if (tap_insn !== 10'h3FF) $display("FAIL bypass_insn: got %h required 3ff", tap_insn);
        else pass_cnt++;
        u0 = upd_cnt;
        dr_scan(8, 64'h4D, 64'd0, out);
        chk_cnt++;
        if (out[7:0] !== 8'b1001_1010) $display("FAIL bypass_tdo: got %b required 10011010", out[7:0]);
        else pass_cnt++;
        chk_cnt++;
        if (upd_cnt - u0 != 1) $display("FAIL bypass_update: got %0d required 1", upd_cnt - u0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_shift();
        logic [9:0]  ir_out;
        logic [63:0] out;
        logic        t;
        int u0;
        ir_scan(10'd5, ir_out);
        tap_tdo_in = '1;
        tck_pulse(1'b1, 1'b0, t);
        tck_pulse(1'b0, 1'b0, t);
        tck_pulse(1'b0, 1'b1, t);
        tck_pulse(1'b0, 1'b1, t);
        chk_cnt++;
        if (tdo_en !== 1'b1 || tdo !== 1'b1)
            $display("FAIL pre_reset_shift: got tdo=%b tdo_en=%b required 1 1", tdo, tdo_en);
        else pass_cnt++;
        u0 = upd_cnt;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (tap_insn !== 10'd0 || tdo !== 1'b0 || tdo_en !== 1'b0)
            $display("FAIL mid_reset_outputs: got insn=%h tdo=%b tdo_en=%b required 000 0 0",
                     tap_insn, tdo, tdo_en);
        else pass_cnt++;
        tck_pulse(1'b1, 1'b0, t);
        tck_pulse(1'b1, 1'b0, t);
        tck_pulse(1'b0, 1'b0, t);
        chk_cnt++;
        if (upd_cnt != u0) $display("FAIL mid_reset_no_update: got %0d required 0", upd_cnt - u0);
        else pass_cnt++;
        dr_scan(32, 64'd0, 64'd0, out);
        chk_cnt++;
        if (out[31:0] !== ID_VAL) $display("FAIL post_reset_idcode: got %h required %h", out[31:0], ID_VAL);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_ir_scan();
        test_board_dr();
        test_bypass();
        test_reset_mid_shift();
        chk_cnt++;
        if (multi_cnt != 0) $display("FAIL single_strobe: got %0d overlaps required 0", multi_cnt);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
